// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Multi-cycle fetch unit: PC owner, imem req/ack fetch,
//               valid/ready hand-off to decode, branch/jump next-PC select.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  funcode,
    output logic [31:0] inst_pc,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_resetPc = RESET_PC & ~32'd3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_imemReq;
    logic        r_instValid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_instPc;
    logic [31:0] r_fetchCount;

    logic [31:0] w_seqPc;
    logic [31:0] w_branchOff;
    logic [31:0] w_nextPc;

    // Branch/jump inputs only matter on the consume edge, so this select
    // feeds the PC register and nothing else.
    always_comb begin
        w_seqPc     = r_instPc + 32'd4;
        w_branchOff = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
        if (jump) begin
            w_nextPc = {w_seqPc[31:28], r_inst[25:0], 2'b00};
        end else if (branch && zero) begin
            w_nextPc = w_seqPc + w_branchOff;
        end else begin
            w_nextPc = w_seqPc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_imemReq    <= 1'b0;
            r_instValid  <= 1'b0;
            r_pc         <= c_resetPc;
            r_inst       <= 32'd0;
            r_instPc     <= 32'd0;
            r_fetchCount <= 32'd0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state     <= FETCH;
                    r_imemReq   <= 1'b1;
                    r_instValid <= 1'b0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_inst      <= imem_rdata;
                        r_instPc    <= r_pc;
                        r_state     <= HOLD;
                        r_imemReq   <= 1'b0;
                        r_instValid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        r_pc         <= w_nextPc & ~32'd3;
                        r_fetchCount <= r_fetchCount + 32'd1;
                        r_state      <= FETCH;
                        r_imemReq    <= 1'b1;
                        r_instValid  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= BOOT;
                    r_imemReq   <= 1'b0;
                    r_instValid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imemReq;
    assign imem_addr   = r_pc;
    assign inst_valid  = r_instValid;
    assign inst        = r_inst;
    assign opcode      = r_inst[31:26];
    assign funcode     = r_inst[5:0];
    assign inst_pc     = r_instPc;
    assign fetch_count = r_fetchCount;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit (vector table,
//               reset corner cases, randomized run against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funcode;
    logic [31:0] inst_pc;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] fetch_count;

    int passed = 0;
    int total  = 0;

    // Reference model state: address of the pending fetch and consumes so far.
    logic [31:0] curPc;
    logic [31:0] count;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .opcode     (opcode),
        .funcode    (funcode),
        .inst_pc    (inst_pc),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    // Next PC from the ISA rules: J replaces the low 28 bits of PC+4,
    // BEQ-taken adds the word offset, everything else falls through.
    function automatic logic [31:0] refNext(input logic [31:0] ipc, input logic [31:0] w,
                                            input logic b, input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = ipc + 32'd4;
        off = int'($signed(w[15:0]));
        if (j)
            return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        if (b && z)
            return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic resetChecks();
        check("rst_req",   {31'd0, imem_req},   32'd0);
        check("rst_addr",  imem_addr,            32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst",  inst,                 32'd0);
        check("rst_op",    {26'd0, opcode},     32'd0);
        check("rst_fn",    {26'd0, funcode},    32'd0);
        check("rst_ipc",   inst_pc,              32'd0);
        check("rst_cnt",   fetch_count,          32'd0);
    endtask

    // One full transaction starting at a negedge with the DUT in FETCH.
    task automatic doFetch(input logic [31:0] word, input int ackDly, input int readyDly,
                           input logic b, input logic j, input logic z,
                           input logic [31:0] expNext);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_up", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, curPc);
        for (int k = 0; k < ackDly; k++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            inst_ready = 1'($urandom);
            {branch, jump, zero} = 3'($urandom);
            @(negedge clk);
            check("stall_req",   {31'd0, imem_req},   32'd1);
            check("stall_addr",  imem_addr,            curPc);
            check("stall_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        inst_ready = 1'($urandom);
        @(negedge clk);
        imem_rdata = $urandom;
        check("got_valid", {31'd0, inst_valid}, 32'd1);
        check("got_req",   {31'd0, imem_req},   32'd0);
        check("got_inst",  inst,                 word);
        check("got_ipc",   inst_pc,              curPc);
        check("got_op",    {26'd0, opcode},     {26'd0, word[31:26]});
        check("got_fn",    {26'd0, funcode},    {26'd0, word[5:0]});
        for (int k = 0; k < readyDly; k++) begin
            imem_ack   = 1'($urandom);
            inst_ready = 1'b0;
            {branch, jump, zero} = 3'($urandom);
            @(negedge clk);
            check("hold_valid", {31'd0, inst_valid}, 32'd1);
            check("hold_req",   {31'd0, imem_req},   32'd0);
            check("hold_inst",  inst,                 word);
            check("hold_fn",    {26'd0, funcode},    {26'd0, word[5:0]});
            check("hold_cnt",   fetch_count,          count);
        end
        imem_ack   = 1'($urandom);
        inst_ready = 1'b1;
        branch     = b;
        jump       = j;
        zero       = z;
        @(negedge clk);
        inst_ready = 1'b0;
        imem_ack   = 1'b0;
        count      = count + 32'd1;
        check("next_req",   {31'd0, imem_req},   32'd1);
        check("next_valid", {31'd0, inst_valid}, 32'd0);
        check("next_addr",  imem_addr,            expNext);
        check("next_cnt",   fetch_count,          count);
        curPc = expNext;
    endtask

    typedef struct {
        logic [31:0] word;
        int          ackDly;
        int          readyDly;
        logic        b;
        logic        j;
        logic        z;
        logic [31:0] expNext;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        vecs[1] = '{32'h0000_0020, 5, 3, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        vecs[2] = '{32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
        vecs[3] = '{32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        vecs[4] = '{32'h1000_FFFE, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0000_000C};
        vecs[5] = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
        vecs[6] = '{32'h0800_0040, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        vecs[7] = '{32'h0800_0004, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
        vecs[8] = '{32'h0800_0040, 0, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0100};
        vecs[9] = '{32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0110};

        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b1;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        curPc      = 32'd0;
        count      = 32'd0;

        @(negedge clk);
        @(negedge clk);
        resetChecks();
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_req",   {31'd0, imem_req},   32'd1);
        check("boot_addr",  imem_addr,            32'd0);
        check("boot_valid", {31'd0, inst_valid}, 32'd0);

        foreach (vecs[i])
            doFetch(vecs[i].word, vecs[i].ackDly, vecs[i].readyDly,
                    vecs[i].b, vecs[i].j, vecs[i].z, vecs[i].expNext);
        doFetch(32'h0800_0008, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0020);

        // Asynchronous reset in the middle of the fetch at 0x20.
        check("mid_addr", imem_addr, 32'h0000_0020);
        imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 resetChecks();
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        rst_n      = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rec_req",   {31'd0, imem_req},   32'd1);
        check("rec_valid", {31'd0, inst_valid}, 32'd0);
        check("rec_addr",  imem_addr,            32'd0);
        check("rec_cnt",   fetch_count,          32'd0);
        curPc = 32'd0;
        count = 32'd0;

        for (int i = 0; i < 150; i++) begin
            logic [31:0] w;
            logic        b, j, z;
            w = $urandom;
            b = 1'($urandom);
            j = 1'($urandom_range(0, 3) == 0);
            z = 1'($urandom);
            doFetch(w, $urandom_range(0, 3), $urandom_range(0, 3), b, j, z,
                    refNext(curPc, w, b, j, z));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Multi-cycle instruction fetch unit for the single-cycle MIPS core. It sits on the producer side of the control decoder. It owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake. It presents each instruction, with its opcode and function fields, to decode over a valid/ready handshake. It takes back the decoder's branch and jump indications plus the ALU zero flag to pick the next PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  word address being fetched (= pc), stable while imem_req.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_ack.
- inst_valid  out  1  inst/opcode/funcode/inst_pc hold a fetched instruction.
- inst_ready  in  1  decode/execute consumes the instruction this cycle.
- inst  out  32  registered instruction word.
- opcode  out  6  inst[31:26].
- funcode  out  6  inst[5:0].
- inst_pc  out  32  address the current inst was fetched from.
- branch  in  1  decoder: current inst is BEQ; sampled only on consume.
- jump  in  1  decoder: current inst is J; sampled only on consume.
- zero  in  1  ALU zero flag for current inst; sampled only on consume.
- fetch_count  out  32  number of instructions consumed since reset, wraps.

## Operation
- States: BOOT, FETCH, HOLD. Reset state is BOOT.
- BOOT: imem_req=0 and inst_valid=0. The next edge goes to FETCH. Any imem_ack here is ignored.
- FETCH: imem_req=1 and imem_addr=pc. On an edge with imem_ack=1: inst <= imem_rdata, inst_pc <= pc, go to HOLD. Otherwise stay.
- HOLD: inst_valid=1 and imem_req=0. On an edge with inst_ready=1 ("consume"): pc <= next_pc, fetch_count += 1, go to FETCH. Otherwise hold and keep all outputs stable.
- next_pc, with seq = inst_pc + 4:
  - jump=1: {seq[31:28], inst[25:0], 2'b00}.
  - Otherwise branch=1 && zero=1: seq + ({{14{inst[15]}}, inst[15:0], 2'b00}).
  - Otherwise: seq.
  - jump has priority if both jump and branch are high.
- Arithmetic is 32-bit modulo 2^32. PC wrap-around from 32'hFFFF_FFFC to 32'h0 is legal and not flagged.
- pc[1:0] is forced to 0 on every load.
- opcode and funcode are pure slices of the inst register. They are meaningful only while inst_valid=1.
- imem_ack is ignored whenever imem_req=0. inst_ready is ignored whenever inst_valid=0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, opcode=0, funcode=0, inst_pc=0, fetch_count=0, pc=RESET_PC.
- Reset asserted mid-operation takes effect immediately (asynchronous). An in-flight fetch is abandoned. The first request after release goes to RESET_PC. An ack arriving in BOOT is dropped.
- Ack latency is unbounded. Ack may arrive in the same cycle req rises (combinational memory), in which case inst_valid rises on the next edge.
- Best-case throughput is one instruction per 2 cycles: FETCH with immediate ack, then HOLD with immediate ready.
- Consume to next imem_req high is 1 edge. imem_addr shows the new pc in that same cycle.
- branch, jump and zero are sampled only on the consume edge. Their values at any other time have no effect.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Test plan
- Reset release with RESET_PC=0 and ack tied high:
  - Edge 1: BOOT→FETCH, imem_addr=0.
  - inst_valid=1 one edge later, with inst=imem_rdata and inst_pc=0.
  - Ready tied high: sequential addresses 0x0, 0x4, 0x8, … appear on imem_addr every 2 cycles.
- Memory stall: ack delayed 5 cycles.
  - imem_req and imem_addr=0x4 stay stable for all 5 cycles.
  - inst_valid stays 0 until the edge after ack.
- Decode stall: inst_ready low for 3 cycles while inst=32'h0000_0020 (add).
  - inst, opcode=0 and funcode=6'h20 held.
  - No new imem_req; fetch_count is unchanged until the consume.
- Branch taken: inst_pc=0x8, inst=32'h1000_FFFE, branch=1, zero=1 at consume → next imem_addr=0x4.
  - Same instruction with zero=0 → 0xC.
- Jump: inst_pc=0x10, inst=32'h0800_0040, jump=1 → next imem_addr=0x100. With branch=1 and zero=1 also asserted, the result is still 0x100.
- Reset mid-fetch: assert rst_n=0 while in FETCH at 0x20, then release.
  - All outputs show their reset values asynchronously.
  - An ack pulse during BOOT is ignored.
  - The next request is to 0x0 and fetch_count=0.
